pid_param_loader: RTL and testbench
===================================

PID_PARAM_LOADER -- requirements
Module: pid_param_loader

Interface
REQ-001 SHALL have parameter BITS, default 32, giving the SPI frame width in bits; legal value is 32 only.
REQ-002 SHALL have parameter FIELD_W, default 8, giving the width of each parameter field; BITS = 4*FIELD_W.
REQ-003 SHALL have port clk, input, 1, clock; reset is synchronous, active-high, sampled on clk.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port cs, input, 1, SPI chip select, active-low, shared with the upstream SPI input shifter.
REQ-006 SHALL have port sck, input, 1, SPI clock, shared with the upstream shifter.
REQ-007 SHALL have port in_buf, input, BITS, the upstream shifter's parallel buffer, used as delivered with no bit inversion.
REQ-008 SHALL have port apply, input, 1, apply strobe; used only when LOADER_SHADOW_EN is defined.
REQ-009 SHALL have ports kp, ki, kd and setpoint, each output, FIELD_W, the active PID parameters.
REQ-010 SHALL have port load_pulse, output, 1, high for one cycle when the active parameters change.
REQ-011 SHALL have port frame_err, output, 1, sticky error flag for a bad frame length.

Function
REQ-012 SHALL register sck_last and cs_last; sck_last SHALL be 0 whenever cs=1; a bit event is sck=0 & sck_last=1 & cs=0, using the same rule as the upstream shifter.
REQ-013 SHALL implement FSM states IDLE, SHIFT and COMMIT.
REQ-014 In IDLE, cs=0 SHALL move the FSM to SHIFT and clear bit_cnt to 0.
REQ-015 In SHIFT, each bit event SHALL increment bit_cnt; bit_cnt SHALL saturate at BITS+1 and never wrap.
REQ-016 In SHIFT, the cycle with cs=1 & cs_last=0 is frame end: bit_cnt==BITS SHALL move the FSM to COMMIT; otherwise it SHALL set frame_err and move to IDLE, leaving the parameters unchanged.
REQ-017 COMMIT SHALL last exactly one cycle and then return to IDLE; at its exit edge it SHALL capture in_buf with field map kp=[31:24], ki=[23:16], kd=[15:8], setpoint=[7:0].
REQ-018 load_pulse SHALL be high in the single cycle after the edge that updates the active parameters.
REQ-019 Latency from the frame-end cycle to the update of kp/ki/kd/setpoint SHALL be 2 clk edges (shadow disabled).
REQ-020 A successful commit SHALL clear frame_err.
REQ-021 cs falling while in COMMIT SHALL be honoured: the FSM goes to IDLE, then to SHIFT on the next cycle; bit events in that single lost cycle are an accepted limitation (SCK at least 4x slower than clk).
REQ-022 Bit events while the FSM is in IDLE SHALL be ignored.

Reset
REQ-023 reset SHALL force state=IDLE, bit_cnt=0, sck_last=0, cs_last=1, kp=ki=kd=setpoint=0, load_pulse=0, frame_err=0, shadow=0 and pending=0.
REQ-024 reset mid-frame SHALL discard the frame; the cs low that remains after reset SHALL start a new SHIFT whose bit_cnt starts at 0.

Configuration
REQ-025 Macro LOADER_SHADOW_EN SHALL control staged updates.
REQ-026 With LOADER_SHADOW_EN defined, COMMIT SHALL write a shadow register and set pending; the active outputs SHALL load from shadow on the first cycle with apply=1 & pending=1, clearing pending, and load_pulse SHALL follow that load.
REQ-027 With LOADER_SHADOW_EN defined, when COMMIT exit and apply coincide, apply SHALL take the old shadow only if pending=1 (otherwise no load); the new frame SHALL remain pending.
REQ-028 Without LOADER_SHADOW_EN, apply SHALL be ignored and COMMIT SHALL write the active outputs directly.

Structure
REQ-029 Package pid_pkg SHALL hold FIELD_W, the field MSB/LSB constants and the FSM state enum.
REQ-030 Sub-module pid_frame_counter SHALL hold the sck/cs edge detection and the saturating bit_cnt, and SHALL output bit_event, frame_end and len_ok.

Verification
REQ-031 Bench SHALL drive in_buf directly and check: reset, then a 32-bit frame with in_buf=0x11223344 -> kp=0x11, ki=0x22, kd=0x33, setpoint=0x44 two edges after cs rise; load_pulse high for 1 cycle; frame_err=0.
REQ-032 Check: 31-bit frame -> frame_err=1, parameters unchanged, no load_pulse; a following good frame 0xA0B0C0D0 -> frame_err=0, kp=0xA0.
REQ-033 Check: 40 falling edges -> bit_cnt saturates at 33, frame_err=1, no wrap to a false match.
REQ-034 Check: reset asserted after 16 bits with cs held low, released, then 32 more bits -> commit succeeds.
REQ-035 Check with LOADER_SHADOW_EN: frame 0x01020304 gives no output change until apply=1; apply coincident with a second commit of 0x05060708 -> outputs 0x01.. first, then 0x05.. on the next apply.
REQ-036 Check: SCK toggling while cs=1 -> bit_cnt stays 0, no state change.

Source files
------------

// File: rtl/pid_pkg.sv
// Shared constants and FSM encoding for the PID parameter loader.
// Field map of the 32-bit SPI frame: kp | ki | kd | setpoint, MSB first.
package pid_pkg;

  localparam int FIELD_W = 8;

  localparam int KP_MSB = 31;
  localparam int KP_LSB = 24;
  localparam int KI_MSB = 23;
  localparam int KI_LSB = 16;
  localparam int KD_MSB = 15;
  localparam int KD_LSB = 8;
  localparam int SP_MSB = 7;
  localparam int SP_LSB = 0;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_t;

endpackage

// File: rtl/pid_frame_counter.sv
// SPI edge detection and saturating bit counter for the PID parameter loader.
// Bit events follow the upstream shifter rule: SCK falling while cs is low.
module pid_frame_counter
  import pid_pkg::*;
#(
  parameter int BITS  = 32,
  parameter int CNT_W = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic cs,
  input  logic sck,
  input  logic clr_i,
  input  logic cnt_en_i,
  output logic bit_event_o,
  output logic frame_end_o,
  output logic len_ok_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BITS + 1);
  localparam logic [CNT_W-1:0] CNT_LEN = CNT_W'(BITS);

  logic             sck_last_q;
  logic             cs_last_q;
  logic [CNT_W-1:0] bit_cnt_q;
  logic [CNT_W-1:0] bit_cnt_d;

  // Saturating at BITS+1 keeps an overlong frame from wrapping onto a false length match.
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    if (clr_i) begin
      bit_cnt_d = '0;
    end else if (cnt_en_i && (bit_cnt_q != CNT_MAX)) begin
      bit_cnt_d = bit_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sck_last_q <= 1'b0;
      cs_last_q  <= 1'b1;
      bit_cnt_q  <= '0;
    end else begin
      sck_last_q <= cs ? 1'b0 : sck;
      cs_last_q  <= cs;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

  assign bit_event_o = ~sck & sck_last_q & ~cs;
  assign frame_end_o = cs & ~cs_last_q;
  assign len_ok_o    = (bit_cnt_q == CNT_LEN);

endmodule

// File: rtl/pid_param_loader.sv
// Loads kp/ki/kd/setpoint from a 32-bit SPI frame once the frame length checks out.
// Define LOADER_SHADOW_EN to stage frames in a shadow register released by apply.
module pid_param_loader #(
  parameter int BITS    = 32,
  parameter int FIELD_W = pid_pkg::FIELD_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cs,
  input  logic               sck,
  input  logic [BITS-1:0]    in_buf,
  input  logic               apply,
  output logic [FIELD_W-1:0] kp,
  output logic [FIELD_W-1:0] ki,
  output logic [FIELD_W-1:0] kd,
  output logic [FIELD_W-1:0] setpoint,
  output logic               load_pulse,
  output logic               frame_err
);

  import pid_pkg::*;

  localparam int CNT_W = $clog2(BITS + 2);

  state_t          state_q, state_d;
  logic            bit_event, frame_end, len_ok;
  logic            clr_cnt, cnt_en, commit, err_set;
  logic            load_now;
  logic [BITS-1:0] load_src;
  logic [BITS-1:0] active_q;
  logic            load_pulse_q;
  logic            frame_err_q;

  pid_frame_counter #(
    .BITS (BITS),
    .CNT_W(CNT_W)
  ) u_counter (
    .clk        (clk),
    .reset      (reset),
    .cs         (cs),
    .sck        (sck),
    .clr_i      (clr_cnt),
    .cnt_en_i   (cnt_en),
    .bit_event_o(bit_event),
    .frame_end_o(frame_end),
    .len_ok_o   (len_ok)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // COMMIT always drops back to IDLE; a cs fall seen there is picked up from IDLE next cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!cs) state_d = SHIFT;
      SHIFT:   if (frame_end) state_d = len_ok ? COMMIT : IDLE;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    clr_cnt = (state_q == IDLE) && !cs;
    cnt_en  = (state_q == SHIFT) && bit_event;
    commit  = (state_q == COMMIT);
    err_set = (state_q == SHIFT) && frame_end && !len_ok;
  end

`ifdef LOADER_SHADOW_EN
  logic [BITS-1:0] shadow_q;
  logic            pending_q;

  // apply releases whatever was already pending; a coinciding commit stays pending.
  assign load_now = apply && pending_q;
  assign load_src = shadow_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      if (commit) shadow_q <= in_buf;
      if (commit)        pending_q <= 1'b1;
      else if (load_now) pending_q <= 1'b0;
    end
  end
`else
  logic unused_apply;
  assign unused_apply = apply;
  assign load_now     = commit;
  assign load_src     = in_buf;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q     <= '0;
      load_pulse_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      if (load_now) active_q <= load_src;
      load_pulse_q <= load_now;
      if (err_set)     frame_err_q <= 1'b1;
      else if (commit) frame_err_q <= 1'b0;
    end
  end

  assign kp         = active_q[KP_MSB:KP_LSB];
  assign ki         = active_q[KI_MSB:KI_LSB];
  assign kd         = active_q[KD_MSB:KD_LSB];
  assign setpoint   = active_q[SP_MSB:SP_LSB];
  assign load_pulse = load_pulse_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_pid_param_loader.sv
// Directed self-checking bench for pid_param_loader; follows LOADER_SHADOW_EN when defined.
module tb_pid_param_loader;
  import pid_pkg::*;

  logic        clk;
  logic        reset;
  logic        cs;
  logic        sck;
  logic [31:0] in_buf;
  logic        apply;
  logic [7:0]  kp, ki, kd, setpoint;
  logic        load_pulse;
  logic        frame_err;

  int total = 0;
  int bad   = 0;

  pid_param_loader dut (
    .clk       (clk),
    .reset     (reset),
    .cs        (cs),
    .sck       (sck),
    .in_buf    (in_buf),
    .apply     (apply),
    .kp        (kp),
    .ki        (ki),
    .kd        (kd),
    .setpoint  (setpoint),
    .load_pulse(load_pulse),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  task automatic checkParams(input string tag, input logic [31:0] exp);
    checkOutput(tag, {kp, ki, kd, setpoint}, exp);
  endtask

  task automatic sendBits(input int n);
    for (int i = 0; i < n; i++) begin
      sck = 1'b1;
      repeat (4) tick();
      sck = 1'b0;
      repeat (4) tick();
    end
  endtask

  // Runs a whole frame and returns just after raising cs (frame-end cycle pending).
  task automatic applyStimulus(input logic [31:0] word, input int nbits, input int expCnt);
    in_buf = word;
    cs     = 1'b0;
    repeat (3) tick();
    sendBits(nbits);
    repeat (2) tick();
    checkOutput("bit_cnt_at_end", 32'(dut.u_counter.bit_cnt_q), 32'(expCnt));
    cs = 1'b1;
  endtask

  task automatic expectCommit(input string tag, input logic [31:0] oldW, input logic [31:0] newW);
    tick();
    checkOutput({tag, "_state_commit"}, 32'(dut.state_q), 32'(COMMIT));
    checkParams({tag, "_hold1"}, oldW);
    tick();
`ifdef LOADER_SHADOW_EN
    checkParams({tag, "_staged"}, oldW);
    checkOutput({tag, "_pulse_staged"}, 32'(load_pulse), 32'd0);
    apply = 1'b1;
    tick();
    apply = 1'b0;
`endif
    checkParams({tag, "_params"}, newW);
    checkOutput({tag, "_pulse"}, 32'(load_pulse), 32'd1);
    checkOutput({tag, "_err"}, 32'(frame_err), 32'd0);
    tick();
    checkOutput({tag, "_pulse_off"}, 32'(load_pulse), 32'd0);
  endtask

  task automatic expectReject(input string tag, input logic [31:0] oldW);
    tick();
    checkOutput({tag, "_state_idle"}, 32'(dut.state_q), 32'(IDLE));
    checkOutput({tag, "_err"}, 32'(frame_err), 32'd1);
    tick();
    checkOutput({tag, "_pulse"}, 32'(load_pulse), 32'd0);
    checkParams({tag, "_params"}, oldW);
    tick();
    checkOutput({tag, "_pulse2"}, 32'(load_pulse), 32'd0);
  endtask

  initial begin
    reset  = 1'b1;
    cs     = 1'b1;
    sck    = 1'b0;
    in_buf = 32'h0;
    apply  = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    $display("[TB] reset state");
    checkParams("rst_params", 32'h0);
    checkOutput("rst_pulse", 32'(load_pulse), 32'd0);
    checkOutput("rst_err", 32'(frame_err), 32'd0);
    checkOutput("rst_state", 32'(dut.state_q), 32'(IDLE));
    checkOutput("rst_cnt", 32'(dut.u_counter.bit_cnt_q), 32'd0);

    $display("[TB] sck toggling with cs high");
    sendBits(5);
    checkOutput("idle_sck_cnt", 32'(dut.u_counter.bit_cnt_q), 32'd0);
    checkOutput("idle_sck_state", 32'(dut.state_q), 32'(IDLE));

    $display("[TB] good frame 11223344");
    applyStimulus(32'h1122_3344, 32, 32);
    expectCommit("f1", 32'h0, 32'h1122_3344);
    checkOutput("f1_kp", 32'(kp), 32'h11);
    checkOutput("f1_sp", 32'(setpoint), 32'h44);

    $display("[TB] short 31-bit frame");
    applyStimulus(32'hDEAD_BEEF, 31, 31);
    expectReject("short", 32'h1122_3344);

    $display("[TB] recovery frame A0B0C0D0");
    applyStimulus(32'hA0B0_C0D0, 32, 32);
    expectCommit("f2", 32'h1122_3344, 32'hA0B0_C0D0);
    checkOutput("f2_kp", 32'(kp), 32'hA0);

    $display("[TB] overlong 40-bit frame");
    applyStimulus(32'h1357_9BDF, 40, 33);
    expectReject("long", 32'hA0B0_C0D0);

    $display("[TB] reset mid-frame");
    in_buf = 32'h5566_7788;
    cs     = 1'b0;
    repeat (3) tick();
    sendBits(16);
    checkOutput("mid_cnt16", 32'(dut.u_counter.bit_cnt_q), 32'd16);
    reset = 1'b1;
    repeat (2) tick();
    checkOutput("mid_rst_cnt", 32'(dut.u_counter.bit_cnt_q), 32'd0);
    checkOutput("mid_rst_state", 32'(dut.state_q), 32'(IDLE));
    checkParams("mid_rst_params", 32'h0);
    checkOutput("mid_rst_err", 32'(frame_err), 32'd0);
    reset = 1'b0;
    repeat (2) tick();
    checkOutput("mid_state_shift", 32'(dut.state_q), 32'(SHIFT));
    checkOutput("mid_cnt0", 32'(dut.u_counter.bit_cnt_q), 32'd0);
    sendBits(32);
    repeat (2) tick();
    checkOutput("mid_cnt32", 32'(dut.u_counter.bit_cnt_q), 32'd32);
    cs = 1'b1;
    expectCommit("mid", 32'h0, 32'h5566_7788);

`ifdef LOADER_SHADOW_EN
    $display("[TB] shadow staging");
    applyStimulus(32'h0102_0304, 32, 32);
    repeat (6) begin
      tick();
      checkParams("sh_hold", 32'h5566_7788);
    end
    applyStimulus(32'h0506_0708, 32, 32);
    tick();
    checkOutput("sh_state_commit", 32'(dut.state_q), 32'(COMMIT));
    apply = 1'b1;
    tick();
    apply = 1'b0;
    checkParams("sh_old_shadow", 32'h0102_0304);
    checkOutput("sh_pulse1", 32'(load_pulse), 32'd1);
    tick();
    checkOutput("sh_pulse1_off", 32'(load_pulse), 32'd0);
    checkParams("sh_still_old", 32'h0102_0304);
    apply = 1'b1;
    tick();
    apply = 1'b0;
    checkParams("sh_new_shadow", 32'h0506_0708);
    checkOutput("sh_pulse2", 32'(load_pulse), 32'd1);
    apply = 1'b1;
    tick();
    apply = 1'b0;
    tick();
    checkOutput("sh_no_pending", 32'(load_pulse), 32'd0);
    checkParams("sh_final", 32'h0506_0708);
`else
    $display("[TB] apply ignored");
    apply = 1'b1;
    repeat (3) tick();
    checkOutput("apply_pulse", 32'(load_pulse), 32'd0);
    checkParams("apply_params", 32'h5566_7788);
    apply = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
